// File: rtl/bcd_sec_counter.sv
// MM:SS BCD elapsed-time counter driven by a synchronized 1 Hz tick,
// with a start/stop/clear run-state FSM and a 4-digit multiplexed
// active-low seven-segment display scan.
module bcd_sec_counter #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       fin,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic       running,
  output logic [3:0] sec_lo,
  output logic [3:0] sec_hi,
  output logic [3:0] min_lo,
  output logic [3:0] min_hi,
  output logic       wrap,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam int unsigned CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t      state_q, state_d;
  logic        s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic        tick_pulse;
  logic        count_en;
  logic [3:0]  sec_lo_q, sec_lo_d, sec_hi_q, sec_hi_d;
  logic [3:0]  min_lo_q, min_lo_d, min_hi_q, min_hi_d;
  logic        wrap_q, wrap_d;
  logic [CW-1:0] scan_q, scan_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  sel_digit;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] r;
    case (v)
      4'd0:    r = 7'b1000000;
      4'd1:    r = 7'b1111001;
      4'd2:    r = 7'b0100100;
      4'd3:    r = 7'b0110000;
      4'd4:    r = 7'b0011001;
      4'd5:    r = 7'b0010010;
      4'd6:    r = 7'b0000010;
      4'd7:    r = 7'b1111000;
      4'd8:    r = 7'b0000000;
      4'd9:    r = 7'b0010000;
      default: r = 7'b1111111;
    endcase
    return r;
  endfunction

  // Two-flop synchronizer plus history flop; pulse marks a rising edge.
  always_comb begin
    s1_d       = tick_in;
    s2_d       = s1_q;
    s3_d       = s2_q;
    tick_pulse = s2_q & ~s3_q;
  end

  // Run-state transitions; clear dominates, start+stop together is a no-op.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else if (start && !stop) begin
      if (state_q != RUN) state_d = RUN;
    end else if (stop && !start) begin
      if (state_q == RUN) state_d = PAUSE;
    end
  end

  // Cascaded BCD increment on a tick in RUN; clear zeroes all digits.
  always_comb begin
    sec_lo_d = sec_lo_q;
    sec_hi_d = sec_hi_q;
    min_lo_d = min_lo_q;
    min_hi_d = min_hi_q;
    wrap_d   = 1'b0;
    count_en = (state_q == RUN) && tick_pulse;
    if (clear) begin
      sec_lo_d = '0;
      sec_hi_d = '0;
      min_lo_d = '0;
      min_hi_d = '0;
    end else if (count_en) begin
      if (sec_lo_q == 4'd9) begin
        sec_lo_d = '0;
        if (sec_hi_q == 4'd5) begin
          sec_hi_d = '0;
          if (min_lo_q == 4'd9) begin
            min_lo_d = '0;
            if (min_hi_q == 4'd5) begin
              min_hi_d = '0;
              wrap_d   = 1'b1;
            end else begin
              min_hi_d = min_hi_q + 4'd1;
            end
          end else begin
            min_lo_d = min_lo_q + 4'd1;
          end
        end else begin
          sec_hi_d = sec_hi_q + 4'd1;
        end
      end else begin
        sec_lo_d = sec_lo_q + 4'd1;
      end
    end
  end

  // Display scan: anode and segment pattern are both derived from the
  // next digit index so they change on the same edge.
  always_comb begin
    scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + CW'(1);
    idx_d  = (scan_q == SCAN_LAST) ? idx_q + 2'd1 : idx_q;
    case (idx_d)
      2'd0:    sel_digit = sec_lo_q;
      2'd1:    sel_digit = sec_hi_q;
      2'd2:    sel_digit = min_lo_q;
      default: sel_digit = min_hi_q;
    endcase
    an_d  = ~(4'b0001 << idx_d);
    seg_d = seg_decode(sel_digit);
  end

  // Tick synchronizer, FSM and digit registers.
  always_ff @(posedge fin or posedge rst) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      state_q  <= IDLE;
      sec_lo_q <= '0;
      sec_hi_q <= '0;
      min_lo_q <= '0;
      min_hi_q <= '0;
      wrap_q   <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      state_q  <= state_d;
      sec_lo_q <= sec_lo_d;
      sec_hi_q <= sec_hi_d;
      min_lo_q <= min_lo_d;
      min_hi_q <= min_hi_d;
      wrap_q   <= wrap_d;
    end
  end

  // Display scan registers.
  always_ff @(posedge fin or posedge rst) begin
    if (rst) begin
      scan_q <= '0;
      idx_q  <= '0;
      an_q   <= 4'b1110;
      seg_q  <= 7'b1000000;
    end else begin
      scan_q <= scan_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign running = (state_q == RUN);
  assign sec_lo  = sec_lo_q;
  assign sec_hi  = sec_hi_q;
  assign min_lo  = min_lo_q;
  assign min_hi  = min_hi_q;
  assign wrap    = wrap_q;
  assign seg     = seg_q;
  assign an      = an_q;

endmodule

// File: tb/tb_bcd_sec_counter.sv
// Bench for bcd_sec_counter: randomized tick/control stimulus checked every
// cycle against a behavioural model holding the count as total seconds.
module tb_bcd_sec_counter;

  localparam int SCAN = 4;

  logic       fin = 1'b0;
  logic       rst = 1'b1;
  logic       tick_in = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic       running;
  logic [3:0] sec_lo, sec_hi, min_lo, min_hi;
  logic       wrap;
  logic [6:0] seg;
  logic [3:0] an;

  int n_pass = 0;
  int n_total = 0;
  int wrap_cnt = 0;

  bcd_sec_counter #(.SCAN_DIV(SCAN)) dut (
    .fin(fin), .rst(rst), .tick_in(tick_in), .start(start), .stop(stop),
    .clear(clear), .running(running), .sec_lo(sec_lo), .sec_hi(sec_hi),
    .min_lo(min_lo), .min_hi(min_hi), .wrap(wrap), .seg(seg), .an(an)
  );

  always #5 fin = ~fin;

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  function automatic logic [6:0] glyph(input int v);
    logic [6:0] t [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000};
    return t[v];
  endfunction

  // digit i of a total-seconds count: 0=sec units ... 3=min tens
  function automatic int dig(input int t, input int i);
    case (i)
      0:       return t % 10;
      1:       return (t / 10) % 6;
      2:       return (t / 60) % 10;
      default: return t / 600;
    endcase
  endfunction

  // ---------------- behavioural model ----------------
  int         m_tot = 0;     // elapsed seconds 0..3599
  int         m_mode = 0;    // 0 idle, 1 run, 2 pause
  bit         m_wrap = 0;
  int         m_n = 0;       // fin edges since reset release
  int         m_ecnt = 0;
  int         m_due = -1;    // edge at which the pending tick takes effect
  bit         m_prev = 0;
  bit         m_pulse;
  int         m_idx;
  logic [3:0] m_an = 4'b1110;
  logic [6:0] m_seg = 7'b1000000;

  always @(posedge fin or posedge rst) begin
    if (rst) begin
      m_tot = 0; m_mode = 0; m_wrap = 0; m_n = 0; m_ecnt = 0; m_due = -1;
      m_prev = 0; m_an = 4'b1110; m_seg = 7'b1000000;
    end else begin
      m_ecnt++;
      // a rising edge first sampled on edge k takes effect on edge k+2
      if (tick_in && !m_prev) m_due = m_ecnt + 2;
      m_prev  = tick_in;
      m_pulse = (m_ecnt == m_due);
      m_n++;
      m_idx = (m_n / SCAN) % 4;
      m_an  = 4'hF ^ (4'h1 << m_idx);
      m_seg = glyph(dig(m_tot, m_idx));
      m_wrap = 0;
      if (clear) begin
        m_tot = 0; m_mode = 0;
      end else begin
        if (m_mode == 1 && m_pulse) begin
          m_wrap = (m_tot == 3599);
          m_tot  = (m_tot + 1) % 3600;
        end
        if (start && !stop && m_mode != 1) m_mode = 1;
        else if (stop && !start && m_mode == 1) m_mode = 2;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(posedge fin or posedge rst);
      #1;
      if (wrap) wrap_cnt++;
      check("running", running, (m_mode == 1));
      check("sec_lo", sec_lo, dig(m_tot, 0));
      check("sec_hi", sec_hi, dig(m_tot, 1));
      check("min_lo", min_lo, dig(m_tot, 2));
      check("min_hi", min_hi, dig(m_tot, 3));
      check("wrap", wrap, m_wrap);
      check("an", an, m_an);
      check("seg", seg, m_seg);
    end
  end

  // ---------------- stimulus ----------------
  // One tick_in rise; ctl fires on the edge where the tick takes effect:
  // 0 none, 1 start, 2 stop, 3 clear+start.
  task automatic tick(input int ctl);
    tick_in = 1'b1;
    @(negedge fin);
    @(negedge fin);
    start = (ctl == 1 || ctl == 3);
    stop  = (ctl == 2);
    clear = (ctl == 3);
    @(negedge fin);
    start = 1'b0; stop = 1'b0; clear = 1'b0;
    repeat ($urandom_range(0, 1)) @(negedge fin);
    tick_in = 1'b0;
    repeat ($urandom_range(3, 4)) @(negedge fin);
  endtask

  task automatic pulse(input logic s, input logic p, input logic c);
    start = s; stop = p; clear = c;
    @(negedge fin);
    start = 1'b0; stop = 1'b0; clear = 1'b0;
    @(negedge fin);
  endtask

  task automatic check_time(input string nm, input int mh, input int ml,
                            input int sh, input int sl);
    check({nm, ".min_hi"}, min_hi, mh);
    check({nm, ".min_lo"}, min_lo, ml);
    check({nm, ".sec_hi"}, sec_hi, sh);
    check({nm, ".sec_lo"}, sec_lo, sl);
  endtask

  logic [6:0] scan_exp [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
  int         r;

  initial begin
    repeat (3) @(negedge fin);
    rst = 1'b0;
    @(negedge fin);
    check("rst.running", running, 0);
    check("rst.an", an, 4'b1110);
    check("rst.seg", seg, 7'b1000000);

    // ticks in IDLE are discarded
    repeat (3) tick(0);
    check_time("idle", 0, 0, 0, 0);
    check("idle.running", running, 0);

    // count 12 seconds
    pulse(1, 0, 0);
    repeat (12) tick(0);
    check_time("run12", 0, 0, 1, 2);
    check("run12.running", running, 1);
    check("run12.model", m_tot, 12);

    // tick coincident with stop counts; paused ticks are lost
    tick(2);
    repeat (5) tick(0);
    check_time("pause", 0, 0, 1, 3);
    check("pause.running", running, 0);
    pulse(1, 0, 0);
    tick(0);
    check_time("resume", 0, 0, 1, 4);

    // preload to 59:58, then roll over
    repeat (3584) tick(0);
    check_time("pre", 5, 9, 5, 8);
    wrap_cnt = 0;
    tick(0);
    check_time("max", 5, 9, 5, 9);
    check("max.wrapcnt", wrap_cnt, 0);
    tick(0);
    check_time("wrap", 0, 0, 0, 0);
    check("wrap.wrapcnt", wrap_cnt, 1);
    tick(0);
    check_time("after_wrap", 0, 0, 0, 1);
    check("after_wrap.running", running, 1);

    // clear + start + tick pulse in one cycle
    tick(3);
    check_time("clr", 0, 0, 0, 0);
    check("clr.running", running, 0);

    // randomized mix of ticks and control pulses
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6) tick((r < 4) ? 0 : $urandom_range(1, 3));
      else if (r == 6) pulse(1, 0, 0);
      else if (r == 7) pulse(0, 1, 0);
      else if (r == 8) pulse(1, 1, 0);
      else pulse($urandom_range(0, 1), $urandom_range(0, 1), 1);
    end

    // reach 12:34 and check the display scan
    pulse(0, 0, 1);
    pulse(1, 0, 0);
    repeat (754) tick(0);
    pulse(0, 1, 0);
    check_time("t1234", 1, 2, 3, 4);
    for (int i = 0; i < 16; i++) begin
      @(negedge fin);
      case (an)
        4'b1110: check("scan.d0", seg, scan_exp[0]);
        4'b1101: check("scan.d1", seg, scan_exp[1]);
        4'b1011: check("scan.d2", seg, scan_exp[2]);
        4'b0111: check("scan.d3", seg, scan_exp[3]);
        default: check("scan.an", an, 4'b1110);
      endcase
    end

    // asynchronous reset mid-scan
    @(negedge fin);
    #2 rst = 1'b1;
    #1;
    check("arst.an", an, 4'b1110);
    check("arst.seg", seg, 7'b1000000);
    check_time("arst", 0, 0, 0, 0);
    repeat (2) @(negedge fin);
    rst = 1'b0;
    repeat (10) @(negedge fin);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bcd_sec_counter.md
Name: bcd_sec_counter

Overview:
- Consumes the 1 Hz square wave produced by the system-clock frequency divider and counts elapsed time as MM:SS in BCD, from 00:00 to 59:59.
- Provides start/stop/clear control through a small run-state FSM.
- Drives a 4-digit multiplexed, active-low seven-segment display.
- Runs entirely on the 50 MHz system clock; the divided wave is treated as an asynchronous data input, never as a clock.

Parameters:
SCAN_DIV, 50000, fin cycles each display digit stays enabled before the scan advances (minimum 2).

Ports:
fin  input  1  system clock, 50 MHz, rising-edge.
rst  input  1  asynchronous, active-high reset.
tick_in  input  1  1 Hz square wave from the divider; asynchronous to fin.
start  input  1  one-cycle pulse, already debounced; begin or resume counting.
stop  input  1  one-cycle pulse, already debounced; pause counting.
clear  input  1  one-cycle pulse, already debounced; zero the count and return to IDLE.
running  output  1  high in the RUN state.
sec_lo  output  4  BCD seconds units, 0-9.
sec_hi  output  4  BCD seconds tens, 0-5.
min_lo  output  4  BCD minutes units, 0-9.
min_hi  output  4  BCD minutes tens, 0-5.
wrap  output  1  one-cycle pulse when the count rolls over from 59:59 to 00:00.
seg  output  7  segment cathodes {g,f,e,d,c,b,a}, active-low.
an  output  4  digit anodes, active-low; an[0] = sec_lo ... an[3] = min_hi.

Behaviour:
- Reset (asynchronous, while rst=1):
  - state=IDLE, all digits 0, running=0, wrap=0.
  - Synchronizer and edge flops cleared to 0.
  - Scan counter=0, an=4'b1110, seg=7'b1000000 (glyph "0").
- Tick path:
  - tick_in passes through a 2-flop synchronizer (s1, s2), then a history flop s3.
  - tick_pulse = s2 & ~s3, one fin cycle wide per rising edge of tick_in.
  - Latency: the digits update on the 3rd rising fin edge at or after the first edge that samples tick_in high.
  - Falling edges of tick_in have no effect.
- FSM, states IDLE, RUN, PAUSE:
  - IDLE: start -> RUN.
  - RUN: stop -> PAUSE.
  - PAUSE: start -> RUN.
  - clear in any state -> IDLE with all digits zeroed on the same edge.
- Event priority within one cycle:
  - clear beats start, stop and tick_pulse.
  - start and stop together (without clear): state unchanged.
  - start in RUN is ignored; stop in IDLE or PAUSE is ignored.
- Counting:
  - Only when state=RUN and tick_pulse=1 on that cycle; tick_pulse in IDLE or PAUSE is discarded, not deferred.
  - A tick arriving on the same cycle as stop still counts, because the state is RUN at that edge.
  - A tick arriving on the same cycle as start (from IDLE or PAUSE) does not count.
- BCD increment, cascaded:
  - sec_lo 9->0 carries into sec_hi.
  - sec_hi 5->0 carries into min_lo.
  - min_lo 9->0 carries into min_hi.
  - min_hi 5->0 completes a wrap to 00:00 and asserts wrap for exactly the cycle after the update edge.
  - Digits never hold non-BCD values. Counting continues in RUN after a wrap.
- Display scan:
  - A free-running counter counts 0..SCAN_DIV-1; at SCAN_DIV-1 it returns to 0 and the digit index advances 0->1->2->3->0.
  - an is one-hot-low for the index.
  - seg is the registered 7-segment decode of the selected digit's current value, so seg and an change on the same edge.
  - Decode (active-low gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Any other value gives 1111111.
  - Scanning is independent of FSM state and runs even in IDLE.
- Reset mid-operation: everything returns to reset values immediately; a tick already in the synchronizer is lost.

Test Plan:
- Reset, then 3 tick_in rising edges with no start -> digits stay 00:00, running=0, seg=1000000 with an=1110.
- start, then 12 tick_in rising edges -> sec_hi=1, sec_lo=2; each increment lands on the 3rd fin edge after tick_in is first sampled high; running=1.
- Counting with stop pulsed, 5 ticks, then start and 1 tick -> value advances by exactly 1 across the paused interval; a tick coincident with stop still counts.
- Preload to 59:58 by ticking in RUN, then 2 ticks -> 59:59 followed by 00:00; wrap high for exactly one cycle; counting continues.
- clear, start and a synchronized tick_pulse all in one cycle -> state=IDLE, digits 00:00, running=0, no increment.
- SCAN_DIV=4 with count 12:34 -> an cycles 1110,1101,1011,0111 every 4 fin cycles; seg shows 0011001, 0110000, 0100100, 1111001 respectively. Assert rst mid-scan -> an=1110 and seg=1000000 immediately.
